// File: rtl/seq_mult_ctrl.sv
// Shift-and-add multiplier sequencer driving an external shared WIDTH-bit adder.
// Optional macro ZERO_SKIP_EN: a zero operand on an accepted start skips RUN and goes straight to DONE.
module seq_mult_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  output logic               add_cin,
  input  logic [WIDTH-1:0]   add_sum,
  input  logic               add_cout,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a, q, m;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   step_sum;
  logic [WIDTH-1:0] a_shift, q_shift;
  logic             accept, is_zero, last_step;

  // The step carry lands directly in A's msb during the shift, so the
  // post-shift C is always 0 and needs no register of its own.
  always_comb begin
    step_sum  = q[0] ? {add_cout, add_sum} : {1'b0, a};
    a_shift   = step_sum[WIDTH:1];
    q_shift   = {step_sum[0], q[WIDTH-1:1]};
    last_step = (count == CW'(1));
    accept    = start && ((state == IDLE) || (state == DONE));
`ifdef ZERO_SKIP_EN
    is_zero   = (multiplicand == '0) || (multiplier == '0);
`else
    is_zero   = 1'b0;
`endif
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = is_zero ? DONE : RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    state_next = start ? (is_zero ? DONE : RUN) : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a       <= '0;
      q       <= '0;
      m       <= '0;
      count   <= '0;
      product <= '0;
    end else if (accept) begin
      m     <= multiplicand;
      q     <= multiplier;
      a     <= '0;
      count <= CW'(WIDTH);
      if (is_zero) product <= '0;
    end else if (state == RUN) begin
      a     <= a_shift;
      q     <= q_shift;
      count <= count - CW'(1);
      if (last_step) product <= {a_shift, q_shift};
    end
  end

  always_comb begin
    busy    = (state == RUN);
    done    = (state == DONE);
    add_a   = busy ? a : '0;
    add_b   = (busy && q[0]) ? m : '0;
    add_cin = 1'b0;
  end

endmodule
